sw_press_decoder: RTL and testbench
===================================

// Module: sw_press_decoder
// PURPOSE
//  Upstream input stage for the RGB PWM controller. Conditions the raw tactile switch SW.
//  - Synchronises and debounces SW.
//  - Classifies each press as short or long.
//  - Short press toggles run_en; long press steps speed_sel.
//  - run_en and speed_sel feed the state timebase (tick gating / interval select).
//  Runs from the 12 MHz board clock.
// PARAMETERS
//  DEBOUNCE_CYCLES    120_000     stable-level cycles to accept an edge (10 ms @ 12 MHz)
//  LONG_PRESS_CYCLES  12_000_000  debounced hold cycles before a press counts as long (1 s)
//  SPEED_COUNT        4           number of speed_sel values, 0..SPEED_COUNT-1
//  Elaboration $error unless DEBOUNCE_CYCLES >= 2, LONG_PRESS_CYCLES > DEBOUNCE_CYCLES
//  and 2 <= SPEED_COUNT <= 4.
// PORTS
//  clk          in   1  12 MHz clock; single clock domain
//  rst_n        in   1  asynchronous, active-low reset
//  sw_n         in   1  raw switch pin, active-low, asynchronous to clk, bouncy
//  pressed      out  1  debounced level, 1 = button held
//  short_press  out  1  1-cycle pulse on debounced release of a press shorter than long
//  long_press   out  1  1-cycle pulse when hold time reaches LONG_PRESS_CYCLES
//  run_en       out  1  run/pause flag, toggled by short_press
//  speed_sel    out  2  speed index, incremented by long_press, wraps SPEED_COUNT-1 -> 0
// BEHAVIOUR
//  Reset values: pressed=0, short_press=0, long_press=0, run_en=1, speed_sel=0.
//    Synchroniser FFs reset to 1 (released). FSM=IDLE, all counters 0.
//  Synchroniser: 2 FFs; sw_s is the second stage. FSM samples sw_s only.
//  Counters:
//    db_cnt: up to DEBOUNCE_CYCLES-1.
//    hold_cnt: width $clog2(LONG_PRESS_CYCLES), saturating.
//  FSM states and transitions:
//    IDLE    : sw_s==0 -> DB_PRS, db_cnt<=0.
//    DB_PRS  : sw_s==1 -> IDLE (bounce rejected, no output change).
//              Else db_cnt++.
//              At db_cnt==DEBOUNCE_CYCLES-1 -> HELD; pressed<=1; hold_cnt<=0.
//    HELD    : hold_cnt++.
//              At hold_cnt==LONG_PRESS_CYCLES-1 -> LONG; pulse long_press; speed_sel step.
//              sw_s==1 -> DB_REL, db_cnt<=0, hold_cnt frozen.
//    LONG    : sw_s==1 -> DB_REL, db_cnt<=0. Else stay; no further pulses.
//    DB_REL  : sw_s==0 -> back to HELD or LONG (long_flag picks which).
//                hold_cnt resumes from its frozen value; no pulse.
//              Else db_cnt++.
//              At db_cnt==DEBOUNCE_CYCLES-1 -> IDLE; pressed<=0.
//                If !long_flag: pulse short_press and toggle run_en in the same cycle.
//  long_flag: set on HELD->LONG, cleared on entry to IDLE.
//  Latency:
//    pressed rises DEBOUNCE_CYCLES+2 (+1 async sampling) clk edges after sw_n settles low.
//    pressed falls DEBOUNCE_CYCLES+2 (+1) clk edges after sw_n settles high.
//  Pulse rules:
//    short_press and long_press are registered, high exactly 1 cycle, never both in one cycle.
//    At most one pulse per press.
//  speed_sel wraps SPEED_COUNT-1 -> 0. run_en changes only on short_press.
//  Boundaries:
//    Bounce shorter than DEBOUNCE_CYCLES gives no output activity.
//    Holding forever gives exactly one long_press.
//    Release in the same cycle hold_cnt hits its limit: the long transition wins
//      (LONG, then DB_REL).
//    rst_n asserted mid-press: immediate return to reset values, no pulse emitted.
//    Button held while rst_n deasserts: after deassert a full DB_PRS runs, then HELD as usual.
// STRUCTURE
//  sw_ctrl_pkg holds:
//    typedef enum logic [2:0] {IDLE, DB_PRS, HELD, LONG, DB_REL} sw_state_t;
//    default cycle constants SW_DEBOUNCE_10MS, SW_LONG_1S.
//  One sub-module: sync_2ff (2-FF synchroniser, parameterised reset value).
//    Reusable for other board inputs.
//  FSM next-state logic in one always_comb; registers in one always_ff(posedge clk, negedge rst_n).
// TESTING
//  All scenarios use DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=40, SPEED_COUNT=4.
//  1. Reset check:
//     rst_n low 3 cycles -> pressed=0, run_en=1, speed_sel=0, no pulses.
//  2. Bounce rejection:
//     sw_n low 5 cycles then high, repeated 4x -> pressed stays 0, no pulses.
//  3. Short press:
//     sw_n low 20 cycles then high -> pressed=1 at ~cycle 10.
//     One short_press pulse ~10 cycles after release; run_en 1->0.
//     A second identical press returns run_en to 1.
//  4. Long press:
//     sw_n low 100 cycles -> one long_press ~40 cycles after pressed rises; speed_sel 0->1.
//     Release gives no short_press.
//     4 long presses total -> speed_sel wraps to 0.
//  5. Release bounce:
//     hold 20, high 4, low 3, high 12 -> single short_press, pressed falls once.
//     hold_cnt resumes correctly.
//  6. Mid-press reset:
//     rst_n pulsed low while in HELD -> outputs back to reset values, no pulse.
//     Re-debounce before pressed=1.

Source files
------------

// File: rtl/sw_ctrl_pkg.sv
// Shared types and constants for the switch conditioning logic.
//   sw_state_t       : press-decoder FSM states
//   SW_DEBOUNCE_10MS : 10 ms of stable level at 12 MHz
//   SW_LONG_1S       : 1 s hold at 12 MHz
//   speed_step()     : next speed index with wrap at count-1
package sw_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRS,
        HELD,
        LONG,
        DB_REL
    } sw_state_t;

    localparam int unsigned SW_DEBOUNCE_10MS = 120_000;
    localparam int unsigned SW_LONG_1S       = 12_000_000;

    // Advance a 2-bit speed index, wrapping from count-1 back to 0.
    function automatic logic [1:0] speed_step(input logic [1:0] cur, input logic [1:0] last);
        return (cur == last) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous board inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into both stages
//   d     : asynchronous input
//   q     : synchronised output (second stage)
module sync_2ff #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sw_press_decoder.sv
// Tactile switch front end for the RGB PWM controller.
// Synchronises and debounces the raw active-low switch, classifies each press
// as short or long, and turns those into the run/pause flag and speed index.
//   clk         : 12 MHz board clock
//   rst_n       : asynchronous active-low reset
//   sw_n        : raw switch pin, active-low, asynchronous, bouncy
//   pressed     : debounced level, 1 while held
//   short_press : 1-cycle pulse on debounced release of a short press
//   long_press  : 1-cycle pulse when the hold reaches LONG_PRESS_CYCLES
//   run_en      : run/pause flag, toggled by short_press
//   speed_sel   : speed index, stepped by long_press, wraps at SPEED_COUNT-1
module sw_press_decoder
    import sw_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = SW_DEBOUNCE_10MS,
    parameter int unsigned LONG_PRESS_CYCLES = SW_LONG_1S,
    parameter int unsigned SPEED_COUNT       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_n,
    output logic       pressed,
    output logic       short_press,
    output logic       long_press,
    output logic       run_en,
    output logic [1:0] speed_sel
);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
            $error("sw_press_decoder: DEBOUNCE_CYCLES must be >= 2");
        end
        if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
            $error("sw_press_decoder: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
        end
        if (SPEED_COUNT < 2 || SPEED_COUNT > 4) begin : g_bad_speed
            $error("sw_press_decoder: SPEED_COUNT must be in 2..4");
        end
    endgenerate

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [1:0]        SPEED_LAST = 2'(SPEED_COUNT - 1);

    // Released level is 1, so the synchroniser comes out of reset idle.
    logic sw_s;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_n),
        .q     (sw_s)
    );

    sw_state_t         state_q,   state_d;
    logic [DB_W-1:0]   db_cnt_q,  db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_flag_q, long_flag_d;
    logic              pressed_d, short_d, long_d, run_en_d;
    logic [1:0]        speed_d;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        pressed_d   = pressed;
        short_d     = 1'b0;
        long_d      = 1'b0;
        run_en_d    = run_en;
        speed_d     = speed_sel;

        case (state_q)
            IDLE: begin
                long_flag_d = 1'b0;
                if (!sw_s) begin
                    state_d  = DB_PRS;
                    db_cnt_d = '0;
                end
            end

            DB_PRS: begin
                if (sw_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = HELD;
                    pressed_d  = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            HELD: begin
                // Reaching the limit beats a simultaneous release: the press
                // is long, and the release is picked up from LONG next cycle.
                // This branch also caps hold_cnt, so it never wraps.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = LONG;
                    long_d      = 1'b1;
                    long_flag_d = 1'b1;
                    speed_d     = speed_step(speed_sel, SPEED_LAST);
                end else if (sw_s) begin
                    state_d  = DB_REL;
                    db_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            LONG: begin
                if (sw_s) begin
                    state_d  = DB_REL;
                    db_cnt_d = '0;
                end
            end

            DB_REL: begin
                // hold_cnt is left untouched here so a release bounce does
                // not lose accumulated hold time.
                if (!sw_s) begin
                    state_d = long_flag_q ? LONG : HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    pressed_d   = 1'b0;
                    long_flag_d = 1'b0;
                    if (!long_flag_q) begin
                        short_d  = 1'b1;
                        run_en_d = ~run_en;
                    end
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            pressed     <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            run_en      <= 1'b1;
            speed_sel   <= 2'd0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            pressed     <= pressed_d;
            short_press <= short_d;
            long_press  <= long_d;
            run_en      <= run_en_d;
            speed_sel   <= speed_d;
        end
    end

endmodule

// File: tb/tb_sw_press_decoder.sv
// Scoreboard bench for sw_press_decoder with DEBOUNCE_CYCLES=8,
// LONG_PRESS_CYCLES=40, SPEED_COUNT=4. Stimulus pushes expected output events
// (with the clock edge they must follow); a negedge monitor pops and compares.
// Edge numbering: a segment starting right after edge "base" has its first
// sample on edge base+1. A debounced press rises on base+11; a release whose
// first high sample is edge r is accepted on edge r+10.
module tb_sw_press_decoder;

    localparam int unsigned D = 8;
    localparam int unsigned L = 40;
    localparam int unsigned S = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_n  = 1'b1;
    logic       pressed, short_press, long_press, run_en;
    logic [1:0] speed_sel;

    sw_press_decoder #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .SPEED_COUNT       (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_n        (sw_n),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .run_en      (run_en),
        .speed_sel   (speed_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef enum int {EV_RISE, EV_FALL, EV_SHORT, EV_LONG} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         cyc;
        logic       run_en;
        logic [1:0] speed;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic       exp_run   = 1'b1;
    logic [1:0] exp_speed = 2'd0;
    int         base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int c);
        ev_t e;
        e.kind   = k;
        e.cyc    = c;
        e.run_en = exp_run;
        e.speed  = exp_speed;
        exp_q.push_back(e);
    endtask

    task automatic got(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, want none", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind",   k,         e.kind);
            check("ev_cycle",  cyc,       e.cyc);
            check("ev_run_en", run_en,    e.run_en);
            check("ev_speed",  speed_sel, e.speed);
        end
    endtask

    // Monitor: turns output activity into events, in a fixed per-cycle order.
    logic prev_pressed = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pressed = 1'b0;
        end else begin
            if (pressed === 1'b1 && prev_pressed === 1'b0) got(EV_RISE);
            if (pressed === 1'b0 && prev_pressed === 1'b1) got(EV_FALL);
            if (short_press === 1'b1) got(EV_SHORT);
            if (long_press === 1'b1) got(EV_LONG);
            if (short_press === 1'b1 || long_press === 1'b1)
                check("pulse_exclusive", short_press & long_press, 1'b0);
            prev_pressed = pressed;
        end
    end

    // Drive a level for n clock edges; returns #1 after the last edge.
    task automatic seg(input logic lvl, input int n);
        sw_n = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_levels(input string tag);
        check({tag, "_pressed"}, pressed,   1'b0);
        check({tag, "_run_en"},  run_en,    exp_run);
        check({tag, "_speed"},   speed_sel, exp_speed);
    endtask

    task automatic short_scn();
        base = cyc;
        expect_ev(EV_RISE, base + 11);
        exp_run = ~exp_run;
        expect_ev(EV_FALL,  base + 31);
        expect_ev(EV_SHORT, base + 31);
        seg(1'b0, 20);
        seg(1'b1, 15);
        check_levels("short");
    endtask

    task automatic long_scn();
        base = cyc;
        expect_ev(EV_RISE, base + 11);
        exp_speed = (exp_speed == 2'(S - 1)) ? 2'd0 : exp_speed + 2'd1;
        expect_ev(EV_LONG, base + 51);
        expect_ev(EV_FALL, base + 111);
        seg(1'b0, 100);
        seg(1'b1, 15);
        check_levels("long");
    endtask

    initial begin
        // 1. Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_pressed", pressed,     1'b0);
        check("rst_short",   short_press, 1'b0);
        check("rst_long",    long_press,  1'b0);
        check("rst_run_en",  run_en,      1'b1);
        check("rst_speed",   speed_sel,   2'd0);
        rst_n = 1'b1;
        seg(1'b1, 5);
        check_levels("post_rst");

        // 2. Bounce rejection, including the longest rejected low run (D samples)
        for (int i = 0; i < 4; i++) begin
            seg(1'b0, 5);
            seg(1'b1, 5);
        end
        seg(1'b0, D);
        seg(1'b1, 10);
        check_levels("bounce");

        // 3. Two short presses: run_en 1 -> 0 -> 1
        short_scn();
        check("short1_run_en", run_en, 1'b0);
        short_scn();
        check("short2_run_en", run_en, 1'b1);

        // 4. Four long presses: speed 1,2,3 then wrap to 0
        for (int i = 0; i < 4; i++) long_scn();
        check("long_wrap_speed", speed_sel, 2'd0);

        // 5. Release bounce during a short press
        base = cyc;
        expect_ev(EV_RISE, base + 11);
        exp_run = ~exp_run;
        expect_ev(EV_FALL,  base + 38);
        expect_ev(EV_SHORT, base + 38);
        seg(1'b0, 20);
        seg(1'b1, 4);
        seg(1'b0, 3);
        seg(1'b1, 12);
        seg(1'b1, 5);
        check_levels("rel_bounce");

        // 5b. Release bounce mid-hold: hold_cnt 21 frozen, resumes, long on +56
        base = cyc;
        expect_ev(EV_RISE, base + 11);
        exp_speed = exp_speed + 2'd1;
        expect_ev(EV_LONG, base + 56);
        expect_ev(EV_FALL, base + 75);
        seg(1'b0, 30);
        seg(1'b1, 4);
        seg(1'b0, 30);
        seg(1'b1, 15);
        check_levels("resume");
        check("resume_speed", speed_sel, 2'd1);

        // 6. Reset while HELD, button still down through deassert
        base = cyc;
        expect_ev(EV_RISE, base + 11);
        seg(1'b0, 25);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_run   = 1'b1;
        exp_speed = 2'd0;
        check("midrst_pressed", pressed,     1'b0);
        check("midrst_pulses",  {short_press, long_press}, 2'b00);
        check("midrst_run_en",  run_en,      1'b1);
        check("midrst_speed",   speed_sel,   2'd0);
        rst_n = 1'b1;
        short_scn();

        seg(1'b1, 10);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
